mult_arbiter: RTL

MULT_ARBITER -- requirements
Module: mult_arbiter

---
 rtl/mult_arbiter_if.sv | 31 +++
 rtl/mult_arbiter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/mult_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and a shared signed
// 16x16 multiplier. The arbiter uses the slave modport. The requesters and
// the multiplier together use the master modport.
interface mult_arbiter_if;
  logic        req0_valid, req1_valid;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_ready, req1_ready;
  logic        res0_valid, res1_valid;
  logic [31:0] res0_data, res1_data;
  logic        res0_ack, res1_ack;
  logic [15:0] mul_a, mul_b;
  logic [31:0] mul_p;

  modport slave (
    input  req0_valid, req0_a, req0_b, res0_ack,
    input  req1_valid, req1_a, req1_b, res1_ack,
    input  mul_p,
    output req0_ready, res0_valid, res0_data,
    output req1_ready, res1_valid, res1_data,
    output mul_a, mul_b
  );

  modport master (
    output req0_valid, req0_a, req0_b, res0_ack,
    output req1_valid, req1_a, req1_b, res1_ack,
    output mul_p,
    input  req0_ready, res0_valid, res0_data,
    input  req1_ready, res1_valid, res1_data,
    input  mul_a, mul_b
  );
endinterface

// File: rtl/mult_arbiter.sv
// mult_arbiter: shares one pipelined signed multiplier (LATENCY cycles)
// between two requesters. Each requester may have one operation
// outstanding, either in flight or held as an unacknowledged result.
// Optional macro MULT_ARB_RR_EN selects round-robin arbitration on a
// conflict. Without the macro, requester 0 always wins a conflict.

// Per-requester result slot. It tracks the in-flight flag, holds the
// captured product until it is acked, and reports busy.
module mult_arb_lane (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue,
  input  logic        capture,
  input  logic        ack,
  input  logic [31:0] mul_p,
  output logic        busy,
  output logic        res_valid,
  output logic [31:0] res_data
);
  logic inflight;

  // Set in-flight on issue and clear it on capture. The result is held
  // until ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight  <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      if (issue)        inflight <= 1'b1;
      else if (capture) inflight <= 1'b0;
      if (capture) begin
        res_valid <= 1'b1;
        res_data  <= mul_p;
      end else if (ack && res_valid) begin
        res_valid <= 1'b0;
      end
    end
  end

  assign busy = inflight | res_valid;
endmodule

module mult_arbiter #(
  parameter int LATENCY = 3
) (
  input  logic     clk,
  input  logic     rst_n,
  mult_arbiter_if.slave bus
);
  localparam int NUM_REQ = 2;

  logic [NUM_REQ-1:0]       req_valid, res_ack, busy, elig, grant, lane_cap, res_valid;
  logic [NUM_REQ-1:0][15:0] req_a, req_b;
  logic [NUM_REQ-1:0][31:0] res_data;
  logic                     issue, grant_id;
  logic [LATENCY:1]         tag_vld, tag_id;

  assign req_valid = {bus.req1_valid, bus.req0_valid};
  assign req_a     = {bus.req1_a, bus.req0_a};
  assign req_b     = {bus.req1_b, bus.req0_b};
  assign res_ack   = {bus.res1_ack, bus.res0_ack};

  // Gating with rst_n keeps every ready low while reset is asserted.
  assign elig = req_valid & ~busy & {NUM_REQ{rst_n}};

`ifdef MULT_ARB_RR_EN
  logic last_id;

  // On a conflict, grant the requester that was not granted last.
  always_comb begin
    grant = elig;
    if (&elig) grant = last_id ? 2'b01 : 2'b10;
  end

  // The last-grant pointer moves only when an operation is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     last_id <= 1'b1;
    else if (issue) last_id <= grant_id;
  end
`else
  // Fixed priority: requester 0 wins every conflict.
  always_comb begin
    grant = elig;
    if (elig[0]) grant = 2'b01;
  end
`endif

  assign issue    = |grant;
  assign grant_id = grant[1];

  // Route the granted operands to the multiplier. Drive zero when idle.
  always_comb begin
    bus.mul_a = '0;
    bus.mul_b = '0;
    if (issue) begin
      bus.mul_a = req_a[grant_id];
      bus.mul_b = req_b[grant_id];
    end
  end

  // Move each {valid, id} tag down the pipeline in step with the multiplier.
  // The tag lands in the last stage in the cycle when mul_p holds its
  // product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld <= '0;
      tag_id  <= '0;
    end else begin
      tag_vld[1] <= issue;
      tag_id[1]  <= grant_id;
      for (int i = 2; i <= LATENCY; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_id[i]  <= tag_id[i-1];
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign lane_cap[g] = tag_vld[LATENCY] & (tag_id[LATENCY] == 1'(g));

    mult_arb_lane u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .issue     (grant[g]),
      .capture   (lane_cap[g]),
      .ack       (res_ack[g]),
      .mul_p     (bus.mul_p),
      .busy      (busy[g]),
      .res_valid (res_valid[g]),
      .res_data  (res_data[g])
    );
  end

  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];
  assign bus.res0_valid = res_valid[0];
  assign bus.res1_valid = res_valid[1];
  assign bus.res0_data  = res_data[0];
  assign bus.res1_data  = res_data[1];
endmodule
